// File: rtl/test_status_led.sv
// Test-fixture status indicator: IDLE/RUN/PASS/FAIL state machine driving a PWM-dimmed RGB LED request.
// Latency: o_state updates on the sampling edge; LED outputs follow o_state one cycle later.
// Backpressure: none; inputs are level flags sampled every cycle and outputs are always valid.
module test_status_led #(
    parameter int CLK_FREQ = 48_000_000,
    parameter int BLINK_HZ = 2,
    parameter int DUTY     = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_running,
    input  logic       i_passed,
    output logic [1:0] o_state,
    output logic       o_led_r,
    output logic       o_led_g,
    output logic       o_led_b
);

    // Half blink period in cycles; FAIL blinks at twice the RUN rate.
    localparam int HALF = CLK_FREQ / (2 * BLINK_HZ);
    localparam int CW   = $clog2(HALF);
    localparam logic [CW-1:0] RUN_LAST  = CW'(HALF - 1);
    localparam logic [CW-1:0] FAIL_LAST = CW'(HALF / 2 - 1);
    localparam logic [4:0]    DUTY_W    = 5'(DUTY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;
    logic [3:0]      pwm_q, pwm_d;
    logic            led_r_q, led_r_d;
    logic            led_g_q, led_g_d;
    logic            led_b_q, led_b_d;
    logic            dim;

    // Next-state decode; a rising i_running always (re)starts a run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_running) state_d = ST_RUN;
            ST_RUN:  if (!i_running) state_d = i_passed ? ST_PASS : ST_FAIL;
            ST_PASS: if (i_running) state_d = ST_RUN;
            ST_FAIL: if (i_running) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Blink timebase: restart lit on any state change, otherwise wrap and toggle phase.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (state_d != state_q) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (state_q == ST_RUN) begin
            if (blink_cnt_q == RUN_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end else if (state_q == ST_FAIL) begin
            if (blink_cnt_q == FAIL_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end else begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end
    end

    // Free-running PWM counter and brightness gate; 5-bit compare lets DUTY=16 mean always on.
    always_comb begin
        pwm_d = pwm_q + 4'd1;
        dim   = ({1'b0, pwm_q} < DUTY_W);
    end

    // LED selection from the current state; registered so LEDs trail o_state by one cycle.
    always_comb begin
        led_r_d = 1'b0;
        led_g_d = 1'b0;
        led_b_d = 1'b0;
        case (state_q)
            ST_RUN:  led_b_d = phase_q & dim;
            ST_PASS: led_g_d = dim;
            ST_FAIL: led_r_d = phase_q & dim;
            default: ;
        endcase
    end

    // State, timebase and LED registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            pwm_q       <= '0;
            led_r_q     <= 1'b0;
            led_g_q     <= 1'b0;
            led_b_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pwm_q       <= pwm_d;
            led_r_q     <= led_r_d;
            led_g_q     <= led_g_d;
            led_b_q     <= led_b_d;
        end
    end

    assign o_state = state_q;
    assign o_led_r = led_r_q;
    assign o_led_g = led_g_q;
    assign o_led_b = led_b_q;

endmodule

// File: tb/tb_test_status_led.sv
// Bench for test_status_led: two instances (DUTY=16 and DUTY=4) share the same stimulus.
// Latency: model pushes the expected post-edge outputs at each edge; monitor pops #1 later.
// Backpressure: none; one expectation per clock edge.
module tb_test_status_led;

    localparam int CLK_FREQ = 64;
    localparam int BLINK_HZ = 4;
    localparam int HALF     = CLK_FREQ / (2 * BLINK_HZ);

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] led16;   // {r,g,b}
        logic [2:0] led4;    // {r,g,b}
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       running;
    logic       passed;
    logic [1:0] st16, st4;
    logic       r16, g16, b16, r4, g4, b4;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    test_status_led #(.CLK_FREQ(CLK_FREQ), .BLINK_HZ(BLINK_HZ), .DUTY(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_running(running), .i_passed(passed),
        .o_state(st16), .o_led_r(r16), .o_led_g(g16), .o_led_b(b16)
    );

    test_status_led #(.CLK_FREQ(CLK_FREQ), .BLINK_HZ(BLINK_HZ), .DUTY(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_running(running), .i_passed(passed),
        .o_state(st4), .o_led_r(r4), .o_led_g(g4), .o_led_b(b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: state name, cycles spent in it, cycles since reset.
    int   m_state = 0;   // 0 IDLE, 1 RUN, 2 PASS, 3 FAIL
    int   m_age   = 0;
    int   m_cyc   = 0;
    int   m_next;
    exp_t m_e;

    function automatic logic [2:0] model_leds(input int s, input int age, input int cyc, input int duty);
        logic lit;
        lit = ((cyc % 16) < duty);
        case (s)
            1:       return {2'b00, lit && ((age / HALF) % 2 == 0)};
            2:       return {1'b0, lit, 1'b0};
            3:       return {lit && ((age / (HALF / 2)) % 2 == 0), 2'b00};
            default: return 3'b000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = 0;
            m_age   = 0;
            m_cyc   = 0;
            m_e     = '0;
        end else begin
            m_e.led16 = model_leds(m_state, m_age, m_cyc, 16);
            m_e.led4  = model_leds(m_state, m_age, m_cyc, 4);
            if (running)          m_next = 1;
            else if (m_state == 1) m_next = passed ? 2 : 3;
            else                  m_next = m_state;
            if (m_next != m_state) m_age = 0;
            else                   m_age = m_age + 1;
            m_state = m_next;
            m_cyc   = m_cyc + 1;
            m_e.st  = 2'(m_state);
        end
        exp_q.push_back(m_e);
    end

    // Monitor: every edge presents a new output set; compare against the queued expectation.
    exp_t got;
    always @(posedge clk) begin
        #1;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL queue_empty t=%0t no expectation available", $time);
        end else begin
            got = exp_q.pop_front();
            if (st16 !== got.st) begin
                errors = errors + 1;
                $display("FAIL state16 t=%0t dut=%0d exp=%0d", $time, st16, got.st);
            end
            checks = checks + 1;
            if ({r16, g16, b16} !== got.led16) begin
                errors = errors + 1;
                $display("FAIL leds16 t=%0t dut=%b exp=%b", $time, {r16, g16, b16}, got.led16);
            end
            checks = checks + 1;
            if (st4 !== got.st) begin
                errors = errors + 1;
                $display("FAIL state4 t=%0t dut=%0d exp=%0d", $time, st4, got.st);
            end
            checks = checks + 1;
            if ({r4, g4, b4} !== got.led4) begin
                errors = errors + 1;
                $display("FAIL leds4 t=%0t dut=%b exp=%b", $time, {r4, g4, b4}, got.led4);
            end
            checks = checks + 1;
            if ($countones({r16, g16, b16}) > 1 || $countones({r4, g4, b4}) > 1) begin
                errors = errors + 1;
                $display("FAIL onehot t=%0t dut16=%b dut4=%b exp=at most one lit",
                         $time, {r16, g16, b16}, {r4, g4, b4});
            end
        end
    end

    task automatic drive(input logic r, input logic run, input logic p, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst_n   = r;
            running = run;
            passed  = p;
        end
    endtask

    logic rnd_run;

    initial begin
        rst_n   = 1'b0;
        running = 1'b1;
        passed  = 1'b0;
        // Reset held with running high, then a long RUN blink.
        drive(1'b0, 1'b1, 1'b0, 3);
        drive(1'b1, 1'b1, 1'b0, 40);
        // Pass path, sticky against a passed=0 pulse; long enough for DUTY=4 dimming.
        drive(1'b1, 1'b0, 1'b1, 20);
        drive(1'b1, 1'b0, 1'b0, 1);
        drive(1'b1, 1'b0, 1'b1, 34);
        // Re-run then fail path, then re-run restarts blue lit.
        drive(1'b1, 1'b1, 1'b1, 10);
        drive(1'b1, 1'b0, 1'b0, 20);
        drive(1'b1, 1'b1, 1'b0, 20);
        // Enter FAIL and reset while red is lit; IDLE then holds with running low.
        drive(1'b1, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0, 1);
        drive(1'b1, 1'b0, 1'b1, 6);
        drive(1'b1, 1'b0, 1'b0, 6);
        // Randomized operation with occasional resets and long running/idle stretches.
        rnd_run = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 23) == 0) rnd_run = ~rnd_run;
            drive(($urandom_range(0, 99) != 0), rnd_run, 1'($urandom_range(0, 1)), 1);
        end
        drive(1'b1, 1'b0, 1'b0, 2);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
